// File: rtl/fht_stage_sequencer.sv
// FHT stage sequencer: walks A_BIT+log2(N_BANK) butterfly stages over N_BANK ping-pong banks.
// Optional build macro FHT_BITREV_EN: stage 0 reads in bit-reversed order for input reordering.
module fht_stage_sequencer #(
  parameter int A_BIT  = 8,
  parameter int N_BANK = 4,
  parameter int LAT    = 4,
  localparam int BK_W   = $clog2(N_BANK),
  localparam int ST_NUM = A_BIT + BK_W,
  localparam int ST_W   = $clog2(ST_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [A_BIT-1:0]  addr_rd,
  output logic [A_BIT-1:0]  addr_wr,
  output logic [A_BIT-1:0]  addr_coef,
  output logic [BK_W-1:0]   bank_mask,
  output logic              rd_en,
  output logic              we_a,
  output logic              we_b,
  output logic [ST_W-1:0]   stage,
  output logic              st_zero,
  output logic              st_last,
  output logic              done,
  output logic              rdy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam int DR_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [ST_W-1:0]  A_BIT_ST  = ST_W'(A_BIT);
  localparam logic [ST_W-1:0]  LAST_ST   = ST_W'(ST_NUM - 1);
  localparam logic [DR_W-1:0]  DRAIN_END = DR_W'(LAT - 1);
  localparam logic [A_BIT-1:0] CNT_END   = '1;

  state_t            state_reg;
  logic [A_BIT-1:0]  cnt_reg;
  logic [DR_W-1:0]   drain_reg;
  logic [ST_W-1:0]   stage_reg;
  logic [A_BIT-1:0]  addr_rd_reg;
  logic [A_BIT-1:0]  addr_coef_reg;
  logic [BK_W-1:0]   bank_mask_reg;
  logic              rd_en_reg;
  logic              st_zero_reg;
  logic              st_last_reg;
  logic              done_reg;
  logic              rdy_reg;
  logic [ST_W-1:0]   stage_next;

  assign stage_next = stage_reg + ST_W'(1);

  // In-bank stage s pairs words whose addresses differ only in bit s.
  function automatic logic [A_BIT-1:0] f_rd_addr(input logic [A_BIT-1:0] c,
                                                 input logic [ST_W-1:0]  s);
    logic [A_BIT-1:0] mask;
    logic [A_BIT-1:0] lo;
    logic [A_BIT-1:0] hi;
    logic [A_BIT-1:0] mid;
    logic [A_BIT-1:0] r;
    r = c;
    if (s < A_BIT_ST) begin
      mask = (A_BIT'(1) << s) - A_BIT'(1);
      lo   = (c >> 1) & mask;
      hi   = (c >> (s + ST_W'(1))) << (s + ST_W'(1));
      mid  = A_BIT'(c[0]) << s;
      r    = hi | mid | lo;
    end
`ifdef FHT_BITREV_EN
    if (s == '0) begin
      for (int i = 0; i < A_BIT; i++) begin
        r[i] = c[A_BIT-1-i];
      end
    end
`endif
    return r;
  endfunction

  function automatic logic [A_BIT-1:0] f_coef_addr(input logic [A_BIT-1:0] c,
                                                   input logic [ST_W-1:0]  s);
    logic [A_BIT-1:0] mask;
    logic [A_BIT-1:0] lo;
    logic [A_BIT-1:0] r;
    r = c;
    if (s < A_BIT_ST) begin
      mask = (A_BIT'(1) << s) - A_BIT'(1);
      lo   = (c >> 1) & mask;
      r    = lo << (A_BIT_ST - s);
    end
    return r;
  endfunction

  function automatic logic [BK_W-1:0] f_bank_mask(input logic [ST_W-1:0] s);
    logic [BK_W-1:0] r;
    r = '0;
    if (s >= A_BIT_ST) begin
      r = BK_W'(1) << (s - A_BIT_ST);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      drain_reg     <= '0;
      stage_reg     <= '0;
      addr_rd_reg   <= '0;
      addr_coef_reg <= '0;
      bank_mask_reg <= '0;
      rd_en_reg     <= 1'b0;
      st_zero_reg   <= 1'b0;
      st_last_reg   <= 1'b0;
      done_reg      <= 1'b0;
      rdy_reg       <= 1'b1;
    end else if (abort) begin
      state_reg   <= S_IDLE;
      rd_en_reg   <= 1'b0;
      st_zero_reg <= 1'b0;
      st_last_reg <= 1'b0;
      done_reg    <= 1'b0;
      rdy_reg     <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_RUN;
            cnt_reg       <= '0;
            stage_reg     <= '0;
            addr_rd_reg   <= f_rd_addr('0, '0);
            addr_coef_reg <= f_coef_addr('0, '0);
            bank_mask_reg <= f_bank_mask('0);
            rd_en_reg     <= 1'b1;
            st_zero_reg   <= 1'b1;
            st_last_reg   <= (LAST_ST == '0);
            rdy_reg       <= 1'b0;
          end
        end
        S_RUN: begin
          if (cnt_reg == CNT_END) begin
            state_reg <= S_DRAIN;
            drain_reg <= '0;
            rd_en_reg <= 1'b0;
          end else begin
            cnt_reg       <= cnt_reg + A_BIT'(1);
            addr_rd_reg   <= f_rd_addr(cnt_reg + A_BIT'(1), stage_reg);
            addr_coef_reg <= f_coef_addr(cnt_reg + A_BIT'(1), stage_reg);
          end
        end
        S_DRAIN: begin
          // The last write of this stage lands in the final drain cycle.
          if (drain_reg == DRAIN_END) begin
            if (stage_reg == LAST_ST) begin
              state_reg   <= S_IDLE;
              done_reg    <= 1'b1;
              rdy_reg     <= 1'b1;
              st_zero_reg <= 1'b0;
              st_last_reg <= 1'b0;
            end else begin
              state_reg     <= S_RUN;
              cnt_reg       <= '0;
              stage_reg     <= stage_next;
              addr_rd_reg   <= f_rd_addr('0, stage_next);
              addr_coef_reg <= f_coef_addr('0, stage_next);
              bank_mask_reg <= f_bank_mask(stage_next);
              rd_en_reg     <= 1'b1;
              st_zero_reg   <= 1'b0;
              st_last_reg   <= (stage_next == LAST_ST);
            end
          end else begin
            drain_reg <= drain_reg + DR_W'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Write side: read address and strobe delayed by the butterfly latency.
  // Even stages write set B, odd stages write set A.
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_dly
      logic [A_BIT-1:0] addr_reg;
      logic             wa_reg;
      logic             wb_reg;
      logic [A_BIT-1:0] addr_in;
      logic             wa_in;
      logic             wb_in;

      if (gi == 0) begin : g_head
        assign addr_in = addr_rd_reg;
        assign wa_in   = rd_en_reg & stage_reg[0];
        assign wb_in   = rd_en_reg & ~stage_reg[0];
      end else begin : g_tail
        assign addr_in = g_dly[gi-1].addr_reg;
        assign wa_in   = g_dly[gi-1].wa_reg;
        assign wb_in   = g_dly[gi-1].wb_reg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          addr_reg <= '0;
          wa_reg   <= 1'b0;
          wb_reg   <= 1'b0;
        end else if (abort) begin
          addr_reg <= '0;
          wa_reg   <= 1'b0;
          wb_reg   <= 1'b0;
        end else begin
          addr_reg <= addr_in;
          wa_reg   <= wa_in;
          wb_reg   <= wb_in;
        end
      end
    end
  endgenerate

  assign addr_rd   = addr_rd_reg;
  assign addr_coef = addr_coef_reg;
  assign bank_mask = bank_mask_reg;
  assign rd_en     = rd_en_reg;
  assign stage     = stage_reg;
  assign st_zero   = st_zero_reg;
  assign st_last   = st_last_reg;
  assign done      = done_reg;
  assign rdy       = rdy_reg;
  assign addr_wr   = g_dly[LAT-1].addr_reg;
  assign we_a      = g_dly[LAT-1].wa_reg;
  assign we_b      = g_dly[LAT-1].wb_reg;

endmodule
